// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: funct3 encodings, error codes, FSM states
// and request classification.
package lsu_pkg;

  localparam logic [2:0] Funct3Lb  = 3'd0;
  localparam logic [2:0] Funct3Lh  = 3'd1;
  localparam logic [2:0] Funct3Lw  = 3'd2;
  localparam logic [2:0] Funct3Lbu = 3'd4;
  localparam logic [2:0] Funct3Lhu = 3'd5;
  localparam logic [2:0] Funct3Sb  = 3'd0;
  localparam logic [2:0] Funct3Sh  = 3'd1;
  localparam logic [2:0] Funct3Sw  = 3'd2;

  typedef enum logic [1:0] {
    ErrNone       = 2'd0,
    ErrMisaligned = 2'd1,
    ErrTimeout    = 2'd2,
    ErrIllegal    = 2'd3
  } lsu_err_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StResp = 2'd2
  } lsu_state_e;

  function automatic logic lsu_is_illegal(input logic load, input logic store,
                                          input logic [2:0] funct3);
    logic illegal;
    illegal = 1'b0;
    if (load == store) begin
      illegal = 1'b1;
    end else if (load) begin
      illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    end else begin
      illegal = (funct3 >= 3'd3);
    end
    return illegal;
  endfunction

  function automatic logic lsu_is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    logic mis;
    mis = 1'b0;
    if (funct3[1:0] == 2'd1) begin
      mis = offset[0];
    end else if (funct3[1:0] == 2'd2) begin
      mis = (offset != 2'b00);
    end
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane formatting: store byte enables and lane replication, and load lane extraction with
// sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    unique case (offset)
      2'd0:    lane_byte = rdata[7:0];
      2'd1:    lane_byte = rdata[15:8];
      2'd2:    lane_byte = rdata[23:16];
      default: lane_byte = rdata[31:24];
    endcase
    lane_half = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be        = 4'b1111;
    wdata     = store_data;
    load_data = rdata;
    unique case (funct3[1:0])
      2'd0: begin
        be        = 4'b0001 << offset;
        wdata     = {4{store_data[7:0]}};
        load_data = funct3[2] ? {24'd0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      end
      2'd1: begin
        be        = offset[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{store_data[15:0]}};
        load_data = funct3[2] ? {16'd0, lane_half} : {{16{lane_half[15]}}, lane_half};
      end
      default: begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit: classifies a request, drives a req/ack data bus with
// timeout, and returns formatted load data or an error code.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        load_i,
  input  logic        store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        done_o,
  output logic [31:0] load_data_o,
  output logic [1:0]  err_o,
  output logic        busy_o
);

  lsu_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  offset_q, offset_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        done_q, done_d;
  logic [31:0] load_data_q, load_data_d;
  logic [1:0]  err_q, err_d;

  logic [2:0]  align_funct3;
  logic [1:0]  align_offset;
  logic [3:0]  align_be;
  logic [31:0] align_wdata;
  logic [31:0] align_load;

  // In IDLE the aligner formats the incoming request; afterwards it extracts from the bus word.
  assign align_funct3 = (state_q == StIdle) ? funct3_i : funct3_q;
  assign align_offset = (state_q == StIdle) ? addr_i[1:0] : offset_q;

  lsu_align u_align (
    .funct3     (align_funct3),
    .offset     (align_offset),
    .store_data (store_data_i),
    .rdata      (mem_rdata_i),
    .be         (align_be),
    .wdata      (align_wdata),
    .load_data  (align_load)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    funct3_d    = funct3_q;
    offset_d    = offset_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    load_data_d = load_data_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          funct3_d = funct3_i;
          offset_d = addr_i[1:0];
          if (lsu_is_illegal(load_i, store_i, funct3_i)) begin
            state_d = StResp;
            done_d  = 1'b1;
            err_d   = ErrIllegal;
          end else if (lsu_is_misaligned(funct3_i, addr_i[1:0])) begin
            state_d = StResp;
            done_d  = 1'b1;
            err_d   = ErrMisaligned;
          end else begin
            state_d     = StReq;
            cnt_d       = 32'd0;
            mem_req_d   = 1'b1;
            mem_we_d    = store_i;
            mem_addr_d  = {addr_i[31:2], 2'b00};
            mem_be_d    = align_be;
            mem_wdata_d = align_wdata;
          end
        end
      end
      StReq: begin
        if (mem_ack_i) begin
          state_d   = StResp;
          done_d    = 1'b1;
          mem_req_d = 1'b0;
          err_d     = ErrNone;
          if (!mem_we_q) begin
            load_data_d = align_load;
          end
        end else if ((TIMEOUT_CYCLES != 0) && ((cnt_q + 32'd1) == TIMEOUT_CYCLES)) begin
          state_d   = StResp;
          done_d    = 1'b1;
          mem_req_d = 1'b0;
          err_d     = ErrTimeout;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= 32'd0;
      funct3_q    <= 3'd0;
      offset_q    <= 2'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      done_q      <= 1'b0;
      load_data_q <= 32'd0;
      err_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      funct3_q    <= funct3_d;
      offset_q    <= offset_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      load_data_q <= load_data_d;
      err_q       <= err_d;
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign busy_o      = req_valid_i || (state_q != StIdle);
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;
  assign done_o      = done_q;
  assign load_data_o = load_data_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a hand-driven req/ack memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        load;
  logic        store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        done;
  logic [31:0] load_data;
  logic [1:0]  err;
  logic        busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Per-access observations filled in by run_access.
  int          o_done_cyc;
  int          o_req_cyc;
  logic [31:0] o_addr;
  logic [3:0]  o_be;
  logic        o_we;
  logic [31:0] o_wdata;
  logic [1:0]  o_err;
  logic [31:0] o_ld;
  logic        o_busy0;
  logic        o_ready0;

  always #5 clk = ~clk;

  load_store_unit #(
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .load_i       (load),
    .store_i      (store),
    .funct3_i     (funct3),
    .addr_i       (addr),
    .store_data_i (store_data),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_be_o     (mem_be),
    .mem_wdata_o  (mem_wdata),
    .mem_ack_i    (mem_ack),
    .mem_rdata_i  (mem_rdata),
    .done_o       (done),
    .load_data_o  (load_data),
    .err_o        (err),
    .busy_o       (busy)
  );

  // Presents one request in cycle 0 and acks on REQ cycle number `waits` (negative: never).
  task automatic run_access(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] d, input int waits,
                            input logic [31:0] rd);
    @(posedge clk); #1;
    req_valid = 1'b1; load = ld; store = st; funct3 = f3; addr = a; store_data = d;
    mem_rdata = rd; mem_ack = 1'b0;
    o_done_cyc = -1; o_req_cyc = 0;
    o_addr = 32'hx; o_be = 4'hx; o_we = 1'bx; o_wdata = 32'hx; o_err = 2'hx; o_ld = 32'hx;
    #1;
    o_busy0 = busy; o_ready0 = req_ready;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      mem_ack = 1'b0;
      if (done) begin
        o_done_cyc = cyc; o_err = err; o_ld = load_data;
        break;
      end
      if (mem_req) begin
        if (o_req_cyc == 0) begin
          o_addr = mem_addr; o_be = mem_be; o_we = mem_we; o_wdata = mem_wdata;
        end
        mem_ack = (waits >= 0) && (o_req_cyc == waits);
        o_req_cyc++;
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; load = 1'b0; store = 1'b0; funct3 = 3'd0;
    addr = 32'd0; store_data = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== 70'd0) begin
      $display("FAIL reset_bus: got req=%b we=%b addr=%h be=%b wdata=%h, want all zero",
               mem_req, mem_we, mem_addr, mem_be, mem_wdata);
    end else pass_cnt++;
    total_cnt++;
    if ({done, load_data, err} !== 35'd0) begin
      $display("FAIL reset_resp: got done=%b load_data=%h err=%0d, want 0/0/0", done,
               load_data, err);
    end else pass_cnt++;
    total_cnt++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL reset_idle: got ready=%b busy=%b, want 1/0", req_ready, busy);
    end else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_store_word;
    run_access(1'b0, 1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'd0);
    total_cnt++;
    if (o_busy0 !== 1'b1 || o_ready0 !== 1'b1) begin
      $display("FAIL sw_accept: got busy=%b ready=%b, want 1/1", o_busy0, o_ready0);
    end else pass_cnt++;
    total_cnt++;
    if (o_addr !== 32'h100 || o_be !== 4'b1111 || o_we !== 1'b1 || o_wdata !== 32'hDEADBEEF) begin
      $display("FAIL sw_bus: got addr=%h be=%b we=%b wdata=%h, want 00000100/1111/1/deadbeef",
               o_addr, o_be, o_we, o_wdata);
    end else pass_cnt++;
    total_cnt++;
    if (o_done_cyc !== 2 || o_err !== 2'd0) begin
      $display("FAIL sw_done: got cycle=%0d err=%0d, want 2/0", o_done_cyc, o_err);
    end else pass_cnt++;
  endtask

  task automatic test_load_byte;
    run_access(1'b1, 1'b0, 3'd0, 32'h0000_0203, 32'd0, 3, 32'h80FF_FF7F);
    total_cnt++;
    if (o_addr !== 32'h200 || o_be !== 4'b1000 || o_we !== 1'b0) begin
      $display("FAIL lb_bus: got addr=%h be=%b we=%b, want 00000200/1000/0", o_addr, o_be, o_we);
    end else pass_cnt++;
    total_cnt++;
    if (o_done_cyc !== 5 || o_ld !== 32'hFFFF_FF80 || o_err !== 2'd0) begin
      $display("FAIL lb_data: got cycle=%0d data=%h err=%0d, want 5/ffffff80/0", o_done_cyc,
               o_ld, o_err);
    end else pass_cnt++;
    run_access(1'b1, 1'b0, 3'd4, 32'h0000_0203, 32'd0, 3, 32'h80FF_FF7F);
    total_cnt++;
    if (o_ld !== 32'h0000_0080) begin
      $display("FAIL lbu_data: got %h, want 00000080", o_ld);
    end else pass_cnt++;
  endtask

  task automatic test_half_word;
    run_access(1'b0, 1'b1, 3'd1, 32'h0000_0102, 32'h0000_1234, 1, 32'd0);
    total_cnt++;
    if (o_addr !== 32'h100 || o_be !== 4'b1100 || o_wdata !== 32'h1234_1234 || o_done_cyc !== 3)
    begin
      $display("FAIL sh_bus: got addr=%h be=%b wdata=%h cycle=%0d, want 00000100/1100/12341234/3",
               o_addr, o_be, o_wdata, o_done_cyc);
    end else pass_cnt++;
    total_cnt++;
    if (load_data !== 32'h0000_0080) begin
      $display("FAIL store_keeps_ld: got %h, want 00000080", load_data);
    end else pass_cnt++;
    run_access(1'b1, 1'b0, 3'd1, 32'h0000_0101, 32'd0, 0, 32'd0);
    total_cnt++;
    if (o_req_cyc !== 0 || o_done_cyc !== 1 || o_err !== 2'd1) begin
      $display("FAIL lh_misaligned: got reqs=%0d cycle=%0d err=%0d, want 0/1/1", o_req_cyc,
               o_done_cyc, o_err);
    end else pass_cnt++;
    total_cnt++;
    if (o_ld !== 32'h0000_0080) begin
      $display("FAIL error_keeps_ld: got %h, want 00000080", o_ld);
    end else pass_cnt++;
    run_access(1'b1, 1'b0, 3'd1, 32'h0000_0402, 32'd0, 0, 32'h9ABC_5678);
    total_cnt++;
    if (o_be !== 4'b1100 || o_ld !== 32'hFFFF_9ABC) begin
      $display("FAIL lh_upper: got be=%b data=%h, want 1100/ffff9abc", o_be, o_ld);
    end else pass_cnt++;
    run_access(1'b1, 1'b0, 3'd5, 32'h0000_0400, 32'd0, 0, 32'h1234_8001);
    total_cnt++;
    if (o_be !== 4'b0011 || o_ld !== 32'h0000_8001) begin
      $display("FAIL lhu_lower: got be=%b data=%h, want 0011/00008001", o_be, o_ld);
    end else pass_cnt++;
    run_access(1'b1, 1'b0, 3'd2, 32'h0000_0404, 32'd0, 2, 32'hCAFE_F00D);
    total_cnt++;
    if (o_addr !== 32'h404 || o_ld !== 32'hCAFE_F00D || o_done_cyc !== 4) begin
      $display("FAIL lw_data: got addr=%h data=%h cycle=%0d, want 00000404/cafef00d/4", o_addr,
               o_ld, o_done_cyc);
    end else pass_cnt++;
    run_access(1'b0, 1'b1, 3'd0, 32'h0000_0001, 32'h0000_00A5, 0, 32'd0);
    total_cnt++;
    if (o_be !== 4'b0010 || o_wdata !== 32'hA5A5_A5A5) begin
      $display("FAIL sb_bus: got be=%b wdata=%h, want 0010/a5a5a5a5", o_be, o_wdata);
    end else pass_cnt++;
  endtask

  task automatic test_timeout;
    run_access(1'b1, 1'b0, 3'd2, 32'h0000_0800, 32'd0, -1, 32'h1111_1111);
    total_cnt++;
    if (o_req_cyc !== 4 || o_done_cyc !== 5 || o_err !== 2'd2) begin
      $display("FAIL timeout: got reqs=%0d cycle=%0d err=%0d, want 4/5/2", o_req_cyc,
               o_done_cyc, o_err);
    end else pass_cnt++;
    run_access(1'b1, 1'b0, 3'd2, 32'h0000_0800, 32'd0, 3, 32'h2222_2222);
    total_cnt++;
    if (o_req_cyc !== 4 || o_done_cyc !== 5 || o_err !== 2'd0 || o_ld !== 32'h2222_2222) begin
      $display("FAIL ack_beats_timeout: got reqs=%0d cycle=%0d err=%0d data=%h, want 4/5/0/22222222",
               o_req_cyc, o_done_cyc, o_err, o_ld);
    end else pass_cnt++;
  endtask

  task automatic test_illegal;
    run_access(1'b1, 1'b1, 3'd2, 32'h0000_0100, 32'd0, 0, 32'd0);
    total_cnt++;
    if (o_req_cyc !== 0 || o_done_cyc !== 1 || o_err !== 2'd3) begin
      $display("FAIL illegal_both: got reqs=%0d cycle=%0d err=%0d, want 0/1/3", o_req_cyc,
               o_done_cyc, o_err);
    end else pass_cnt++;
    run_access(1'b1, 1'b0, 3'd6, 32'h0000_0100, 32'd0, 0, 32'd0);
    total_cnt++;
    if (o_req_cyc !== 0 || o_done_cyc !== 1 || o_err !== 2'd3) begin
      $display("FAIL illegal_f3_6: got reqs=%0d cycle=%0d err=%0d, want 0/1/3", o_req_cyc,
               o_done_cyc, o_err);
    end else pass_cnt++;
    run_access(1'b0, 1'b1, 3'd3, 32'h0000_0100, 32'd0, 0, 32'd0);
    total_cnt++;
    if (o_req_cyc !== 0 || o_err !== 2'd3) begin
      $display("FAIL illegal_store_f3: got reqs=%0d err=%0d, want 0/3", o_req_cyc, o_err);
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid_req;
    int saw_done;
    @(posedge clk); #1;
    req_valid = 1'b1; load = 1'b1; store = 1'b0; funct3 = 3'd2; addr = 32'h0000_0C00;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    total_cnt++;
    if (mem_req !== 1'b1) begin
      $display("FAIL rst_req_start: got mem_req=%b, want 1", mem_req);
    end else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total_cnt++;
    if (mem_req !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1) begin
      $display("FAIL rst_abandon: got mem_req=%b done=%b ready=%b, want 0/0/1", mem_req, done,
               req_ready);
    end else pass_cnt++;
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    saw_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (done || mem_req) saw_done = 1;
    end
    total_cnt++;
    if (saw_done !== 0 || load_data !== 32'd0) begin
      $display("FAIL late_ack: got activity=%0d load_data=%h, want 0/00000000", saw_done,
               load_data);
    end else pass_cnt++;
    run_access(1'b1, 1'b0, 3'd2, 32'h0000_0C00, 32'd0, 0, 32'h0BAD_CAFE);
    total_cnt++;
    if (o_done_cyc !== 2 || o_err !== 2'd0 || o_ld !== 32'h0BAD_CAFE) begin
      $display("FAIL after_reset: got cycle=%0d err=%0d data=%h, want 2/0/0badcafe", o_done_cyc,
               o_err, o_ld);
    end else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_store_word;
    test_load_byte;
    test_half_word;
    test_timeout;
    test_illegal;
    test_reset_mid_req;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
